// File: rtl/digit_entry_fsm.sv
// Purpose: collects keypad digit strobes into a tens/ones BCD pair for the two-digit joiner.
// Latency: every key effect, and a timeout, is visible one cycle after the sampling edge.
// Backpressure: none; every strobed key is accepted or rejected with an err pulse.
module digit_entry_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic       num_valid,
  output logic [1:0] state,
  output logic       err
);

  // Counter just wide enough to hold TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    dig1_q;
  logic [3:0]    dig2_q;
  logic          num_valid_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic key_is_digit;
  logic key_is_clear;
  logic key_is_enter;
  logic counting;
  logic tmo_hit;

  assign key_is_digit = (key_code <= 4'd9);
  assign key_is_clear = (key_code == 4'd10);
  assign key_is_enter = (key_code == 4'd11);

  // Only a partial entry can time out; a key in the expiry cycle takes priority.
  assign counting = (state_q == S_ONE) || (state_q == S_TWO);
  assign tmo_hit  = counting && (cnt_q == TMO_LAST) && !key_valid;

  // Entry FSM: digits, pulses and inactivity counter all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dig1_q      <= 4'd0;
      dig2_q      <= 4'd0;
      num_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Pulses default low; the counter restarts unless explicitly advanced.
      num_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      if (key_valid) begin
        if (key_is_digit) begin
          case (state_q)
            S_IDLE, S_DONE: begin
              dig2_q  <= 4'd0;
              dig1_q  <= key_code;
              state_q <= S_ONE;
            end
            S_ONE: begin
              dig2_q  <= dig1_q;
              dig1_q  <= key_code;
              state_q <= S_TWO;
            end
            default: begin
              // Third digit: entry is full, keep what we have.
              err_q <= 1'b1;
            end
          endcase
        end else if (key_is_clear) begin
          state_q <= S_IDLE;
          dig1_q  <= 4'd0;
          dig2_q  <= 4'd0;
        end else if (key_is_enter) begin
          if (counting) begin
            state_q     <= S_DONE;
            num_valid_q <= 1'b1;
          end else begin
            // Nothing pending to complete.
            err_q <= 1'b1;
          end
        end else begin
          // Codes 12-15 never reach the digits.
          err_q <= 1'b1;
        end
      end else if (tmo_hit) begin
        state_q <= S_IDLE;
        dig1_q  <= 4'd0;
        dig2_q  <= 4'd0;
        err_q   <= 1'b1;
      end else if (counting) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign num_valid = num_valid_q;
  assign state     = state_q;
  assign err       = err_q;

endmodule
